// File: rtl/mem_slave_responder.sv
// Single-ported word RAM that answers strobe/ready memory requests one at a time.
// Read and write completion latencies are set by parameters.
module mem_slave_responder #(
  parameter int A_WIDTH = 32,
  parameter int DEPTH_W = 12,
  parameter int RD_LAT  = 2,
  parameter int WR_LAT  = 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  output logic [31:0]        m_dout,
  input  logic               m_strobe,
  input  logic [3:0]         m_wen,
  input  logic [1:0]         m_size,
  input  logic               m_rw,
  output logic               m_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  state_t               state;
  logic [3:0]           cnt;
  logic [A_WIDTH-1:0]   req_a;
  logic [31:0]          req_din;
  logic [3:0]           req_wen;
  logic [1:0]           req_size;
  logic                 req_rw;

  logic [31:0]          mem [0:(2**DEPTH_W)-1];
  logic [DEPTH_W-1:0]   idx;
  logic                 commit;
  logic                 unused_bits;

  assign idx    = req_a[DEPTH_W+1:2];
  assign commit = (state == BUSY) && (cnt == 4'd0);

  // Size and the non-index address bits are kept with the request but never steer lanes.
  assign unused_bits = ^{req_size, req_a[1:0], req_a[A_WIDTH-1:DEPTH_W+2]};

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      m_ready  <= 1'b0;
      m_dout   <= 32'd0;
      req_a    <= '0;
      req_din  <= 32'd0;
      req_wen  <= 4'd0;
      req_size <= 2'd0;
      req_rw   <= 1'b0;
    end else begin
      m_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (m_strobe) begin
            req_a    <= m_a;
            req_din  <= m_din;
            req_wen  <= m_wen;
            req_size <= m_size;
            req_rw   <= m_rw;
            cnt      <= m_rw ? WR_CNT : RD_CNT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!req_rw) m_dout <= mem[idx];
            // Ready is asserted on entry to RESP, so it is high for exactly the RESP cycle.
            m_ready <= 1'b1;
            state   <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; clearing thousands of words is not wanted, and the
  // reset-controlled state keeps an aborted write from ever reaching commit.
  always_ff @(posedge clk) begin
    if (commit && req_rw) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wen[i]) mem[idx][i*8 +: 8] <= req_din[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_slave_responder.sv
// Directed self-checking bench for mem_slave_responder with default latencies
// (read 2, write 1), covering timing, lane merge, aliasing, strobe and reset cases.
module tb_mem_slave_responder;

  logic        clk;
  logic        clrn;
  logic [31:0] m_a;
  logic [31:0] m_din;
  logic [31:0] m_dout;
  logic        m_strobe;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;
  logic        m_rw;
  logic        m_ready;

  int compared   = 0;
  int mismatched = 0;

  mem_slave_responder #(
    .A_WIDTH(32), .DEPTH_W(12), .RD_LAT(2), .WR_LAT(1)
  ) dut (
    .clk(clk), .clrn(clrn), .m_a(m_a), .m_din(m_din), .m_dout(m_dout),
    .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
    .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one request, drop strobe right after acceptance, and check ready timing and width.
  task automatic do_req(input string tag, input logic rw, input logic [31:0] a,
                        input logic [31:0] din, input logic [3:0] wen, input int lat);
    int found;
    found    = -1;
    m_rw     = rw;
    m_a      = a;
    m_din    = din;
    m_wen    = wen;
    m_size   = 2'b10;
    m_strobe = 1'b1;
    step();
    m_strobe = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (m_ready) begin
        found = n;
        break;
      end
      step();
    end
    check({tag, " latency"}, 32'(found), 32'(lat + 1));
    step();
    check({tag, " pulse width"}, {31'd0, m_ready}, 32'd0);
  endtask

  initial begin
    int n_pulse;
    int pos0;
    int pos1;
    logic [31:0] data0;
    logic [31:0] data1;

    clrn = 1'b0; m_strobe = 1'b0; m_a = 32'd0; m_din = 32'd0;
    m_wen = 4'd0; m_size = 2'd0; m_rw = 1'b0;

    // Reset: strobe high must not be accepted while clrn is low.
    m_strobe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ready in reset", {31'd0, m_ready}, 32'd0);
    end
    check("dout in reset", m_dout, 32'd0);
    m_strobe = 1'b0;
    clrn = 1'b1;
    step();

    // First read after reset: ready at T+3.
    do_req("read 0x10", 1'b0, 32'h0000_0010, 32'd0, 4'd0, 2);

    // Full write then read back.
    do_req("write 0x40 full", 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 1);
    do_req("read 0x40", 1'b0, 32'h0000_0040, 32'd0, 4'd0, 2);
    check("read 0x40 data", m_dout, 32'hDEAD_BEEF);

    // Partial write merges only lane 2.
    do_req("write 0x40 lane2", 1'b1, 32'h0000_0040, 32'h1122_3344, 4'b0100, 1);
    check("dout held over write", m_dout, 32'hDEAD_BEEF);
    do_req("read merged", 1'b0, 32'h0000_0040, 32'd0, 4'd0, 2);
    check("merged data", m_dout, 32'hDE22_BEEF);

    // Upper bits and byte offset are ignored.
    do_req("read alias", 1'b0, 32'h0000_4042, 32'd0, 4'd0, 2);
    check("alias data", m_dout, 32'hDE22_BEEF);

    // Empty byte mask still handshakes and changes nothing.
    do_req("write wen0", 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000, 1);
    do_req("read after wen0", 1'b0, 32'h0000_0040, 32'd0, 4'd0, 2);
    check("wen0 data", m_dout, 32'hDE22_BEEF);

    // Back-to-back reads with strobe held high; address switches during first RESP.
    do_req("write 0x44", 1'b1, 32'h0000_0044, 32'h55AA_55AA, 4'b1111, 1);
    n_pulse = 0; pos0 = -1; pos1 = -1; data0 = 32'd0; data1 = 32'd0;
    m_rw = 1'b0; m_a = 32'h0000_0040; m_strobe = 1'b1;
    step();
    for (int n = 1; n <= 14; n++) begin
      if (m_ready) begin
        n_pulse++;
        if (n_pulse == 1) begin
          pos0  = n;
          data0 = m_dout;
          m_a   = 32'h0000_0044;
        end else if (n_pulse == 2) begin
          pos1     = n;
          data1    = m_dout;
          m_strobe = 1'b0;
        end
      end
      step();
    end
    m_strobe = 1'b0;
    check("b2b pulse count", 32'(n_pulse), 32'd2);
    check("b2b first pos", 32'(pos0), 32'd3);
    check("b2b spacing", 32'(pos1 - pos0), 32'd4);
    check("b2b first data", data0, 32'hDE22_BEEF);
    check("b2b second data", data1, 32'h55AA_55AA);

    // Strobe dropped and inputs scrambled during BUSY: captured read still completes.
    m_rw = 1'b0; m_a = 32'h0000_0044; m_strobe = 1'b1;
    step();
    m_strobe = 1'b0; m_rw = 1'b1; m_a = 32'h0000_0040; m_din = 32'h0; m_wen = 4'b1111;
    pos0 = -1;
    for (int n = 1; n <= 20; n++) begin
      if (m_ready) begin
        pos0 = n;
        break;
      end
      step();
    end
    check("busy drop latency", 32'(pos0), 32'd3);
    check("busy drop data", m_dout, 32'h55AA_55AA);
    step();
    do_req("read 0x40 intact", 1'b0, 32'h0000_0040, 32'd0, 4'd0, 2);
    check("0x40 intact data", m_dout, 32'hDE22_BEEF);

    // Reset during BUSY of a write drops the write and the ready pulse.
    do_req("write 0x80 old", 1'b1, 32'h0000_0080, 32'h0123_4567, 4'b1111, 1);
    m_rw = 1'b1; m_a = 32'h0000_0080; m_din = 32'hCAFE_F00D; m_wen = 4'b1111; m_strobe = 1'b1;
    step();
    m_strobe = 1'b0;
    clrn = 1'b0;
    #1;
    check("abort ready", {31'd0, m_ready}, 32'd0);
    check("abort dout", m_dout, 32'd0);
    step();
    clrn = 1'b1;
    n_pulse = 0;
    for (int n = 0; n < 5; n++) begin
      if (m_ready) n_pulse++;
      step();
    end
    check("abort no pulse", 32'(n_pulse), 32'd0);
    do_req("read 0x80", 1'b0, 32'h0000_0080, 32'd0, 4'd0, 2);
    check("0x80 old data", m_dout, 32'h0123_4567);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_slave_responder.md
Name: mem_slave_responder

Overview:
- Memory-side responder for the data cache's strobe/ready memory port: accepts one request at a time and answers with registered read data or a committed byte-lane write.
- Single-ported word-organised RAM model with programmable read and write latency.
- Sits directly on the cache's m_* port. It is used as the backing store in block-level cache benches and as the on-chip scratch memory behind the cache.
- Port names match the cache's m_* names so the two blocks wire one-to-one.

Parameters:
- A_WIDTH, 32, address width.
- DEPTH_W, 12, log2 of the number of 32-bit words in the array.
- RD_LAT, 2, wait cycles for a read before data is captured; legal range 1..15.
- WR_LAT, 1, wait cycles for a write before it is committed; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- m_a  in  A_WIDTH  byte address. Word index is m_a[DEPTH_W+1:2]; bits [1:0] and all bits above DEPTH_W+1 are ignored, so upper addresses alias.
- m_din  in  32  write data.
- m_dout  out  32  read data.
- m_strobe  in  1  request valid.
- m_wen  in  4  byte enables. Bit3 maps to [31:24], bit0 maps to [7:0]. Used for writes only.
- m_size  in  2  access size. Captured with the request but not used for lane selection; m_wen alone selects lanes.
- m_rw  in  1  0 = read, 1 = write.
- m_ready  out  1  one-cycle completion pulse.

Behaviour:
- Reset state (clrn low, asynchronous):
  - state = IDLE, cnt = 0, m_ready = 0, m_dout = 0, captured request registers = 0.
  - Array contents are not reset.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If m_strobe = 1, capture m_a, m_din, m_wen, m_size and m_rw.
  - Load cnt = (m_rw ? WR_LAT : RD_LAT) - 1, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - While cnt != 0, decrement cnt and stay in BUSY.
  - When cnt == 0:
    - For a captured write, update each array byte lane whose captured wen bit is 1; other lanes are unchanged.
    - For a captured read, load m_dout from the array word.
    - Go to RESP.
- RESP:
  - m_ready = 1 for exactly this cycle; go to IDLE.
  - m_strobe is not sampled in RESP.
- Latency: if a request is accepted in cycle T, m_ready is high in cycle T + LAT + 1.
  - Read with RD_LAT = 2: ready at T+3.
  - Write with WR_LAT = 1: ready at T+2.
- Ready is registered: m_ready is decoded from state RESP only, with no combinational path from m_strobe.
- m_dout:
  - Valid in the RESP cycle of a read.
  - Holds its value until the next read capture; writes never change m_dout.
  - Any read that follows a completed write to the same word returns the merged word.
- Back-to-back requests: if m_strobe is still high in the cycle after RESP, it is accepted as a new request. The minimum request spacing is therefore LAT + 2 cycles.
- m_strobe deasserted while in BUSY: the captured request still completes and m_ready still pulses. This is a protocol violation by the initiator, but the outcome is deterministic.
- Inputs that change while in BUSY are ignored; only the captured copies are used.
- Write with m_wen = 0000: no lanes change, but the full handshake still completes.
- Reset asserted mid-transaction:
  - Takes effect immediately.
  - A write not yet committed is dropped.
  - m_ready never pulses for the aborted request.
  - After clrn rises, the block is in IDLE.

Test Plan:
- Reset then read: assert clrn = 0 then release; read at 0x00000010 with RD_LAT = 2 -> m_ready is 0 throughout reset, and the ready pulse comes exactly 3 cycles after accept, lasting 1 cycle.
- Full write then read: write 0xDEADBEEF with wen = 1111 to 0x00000040, then read 0x00000040 -> write ready at T+2, read returns 0xDEADBEEF.
- Partial write merge: write 0x11223344 with wen = 0100 to the same word -> a subsequent read returns 0xDE22BEEF.
- Aliasing and low bits: read 0x00004042 with DEPTH_W = 12 -> returns the word at index 0x010, the same word as 0x00000040.
- Strobe behaviour:
  - Hold m_strobe high continuously across two reads -> two ready pulses spaced RD_LAT + 2 = 4 cycles apart.
  - Drop m_strobe in BUSY -> ready still pulses once.
- Reset mid-write: pulse clrn low during BUSY of a write of 0xCAFEF00D to 0x80 -> no m_ready pulse, and a later read of 0x80 returns the old contents.
